// File: rtl/seq_pkg.sv
// Shared types and constants for the program-counter sequencer.
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALTED
  } seq_state_t;

  localparam int JT_DEPTH  = 32;
  localparam int DEF_PC_W  = 10;
  localparam int DEF_CNT_W = 16;

endpackage

// File: rtl/pc_sequencer_if.sv
// Decoder/host-facing signals of the PC sequencer; slave is the sequencer side.
interface pc_sequencer_if #(
  parameter int PC_W  = 10,
  parameter int CNT_W = 16
);

  logic             Start;
  logic [PC_W-1:0]  Start_PC;
  logic             Jump_en;
  logic [4:0]       Jump_address;
  logic             Branch_flag;
  logic             Halt;
  logic             Lut_we;
  logic [4:0]       Lut_addr;
  logic [PC_W-1:0]  Lut_data;
  logic [PC_W-1:0]  PC;
  logic             Run;
  logic             Done;
  logic [CNT_W-1:0] Cycle_count;

  modport master (
    output Start, Start_PC, Jump_en, Jump_address, Branch_flag, Halt,
           Lut_we, Lut_addr, Lut_data,
    input  PC, Run, Done, Cycle_count
  );

  modport slave (
    input  Start, Start_PC, Jump_en, Jump_address, Branch_flag, Halt,
           Lut_we, Lut_addr, Lut_data,
    output PC, Run, Done, Cycle_count
  );

endinterface

// File: rtl/pc_sequencer_jump_lut.sv
// Jump target table: one synchronous write port, one combinational read port.
module jump_lut
  import seq_pkg::*;
#(
  parameter int PC_W  = DEF_PC_W,
  parameter int DEPTH = JT_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_we,
  input  logic [AW-1:0]   i_waddr,
  input  logic [PC_W-1:0] i_wdata,
  input  logic [AW-1:0]   i_raddr,
  output logic [PC_W-1:0] o_rdata
);

  logic [PC_W-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/pc_sequencer.sv
// PC register, run/halt controller and per-run cycle counter for the single-cycle core.
module pc_sequencer
  import seq_pkg::*;
#(
  parameter int PC_W  = DEF_PC_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic i_clk,
  input  logic i_rst,
  pc_sequencer_if.slave bus
);

  seq_state_t       r_state;
  logic [PC_W-1:0]  r_pc;
  logic             r_done;
  logic [CNT_W-1:0] r_cnt;

  logic             w_lut_we;
  logic [PC_W-1:0]  w_lut_rdata;

  // Table is frozen while executing so a running program never sees its targets move.
  assign w_lut_we = bus.Lut_we && (r_state != RUN);

  jump_lut #(
    .PC_W  (PC_W),
    .DEPTH (JT_DEPTH)
  ) u_jump_lut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_we    (w_lut_we),
    .i_waddr (bus.Lut_addr),
    .i_wdata (bus.Lut_data),
    .i_raddr (bus.Jump_address),
    .o_rdata (w_lut_rdata)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_pc    <= '0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE, HALTED: begin
          if (bus.Start) begin
            r_state <= RUN;
            r_pc    <= bus.Start_PC;
            r_cnt   <= '0;
            r_done  <= 1'b0;
          end
        end
        RUN: begin
          if (r_cnt != '1) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
          if (bus.Halt) begin
            r_state <= HALTED;
            r_done  <= 1'b1;
          end else if (bus.Jump_en && bus.Branch_flag) begin
            r_pc <= w_lut_rdata;
          end else begin
            r_pc <= r_pc + PC_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.PC          = r_pc;
  assign bus.Run         = (r_state == RUN);
  assign bus.Done        = r_done;
  assign bus.Cycle_count = r_cnt;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer.
module tb_pc_sequencer;

  localparam int PC_W  = 10;
  localparam int CNT_W = 16;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  pc_sequencer_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();

  pc_sequencer #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input int pc, input int run,
                           input int done, input int cnt);
    check({tag, ".pc"},   32'(bus.PC),          32'(pc));
    check({tag, ".run"},  32'(bus.Run),         32'(run));
    check({tag, ".done"}, 32'(bus.Done),        32'(done));
    check({tag, ".cnt"},  32'(bus.Cycle_count), 32'(cnt));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.Start        = 1'b0;
    bus.Start_PC     = '0;
    bus.Jump_en      = 1'b0;
    bus.Jump_address = '0;
    bus.Branch_flag  = 1'b0;
    bus.Halt         = 1'b0;
    bus.Lut_we       = 1'b0;
    bus.Lut_addr     = '0;
    bus.Lut_data     = '0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Idle after reset
    for (int i = 0; i < 5; i++) begin
      check_out("idle", 0, 0, 0, 0);
      tick();
    end

    // Straight-line run from 10, halt while PC=13
    bus.Start_PC = 10'd10;
    bus.Start    = 1'b1;
    tick();
    bus.Start = 1'b0;
    check_out("run0", 10, 1, 0, 0);
    tick();
    check_out("run1", 11, 1, 0, 1);
    tick();
    check_out("run2", 12, 1, 0, 2);
    tick();
    check_out("run3", 13, 1, 0, 3);
    bus.Halt = 1'b1;
    tick();
    bus.Halt = 1'b0;
    check_out("halt", 13, 0, 1, 4);
    tick();
    check_out("halt_hold", 13, 0, 1, 4);

    // LUT write and restart on the same edge from HALTED
    bus.Lut_we   = 1'b1;
    bus.Lut_addr = 5'd7;
    bus.Lut_data = 10'd200;
    bus.Start_PC = 10'd0;
    bus.Start    = 1'b1;
    tick();
    clear_inputs();
    check_out("restart", 0, 1, 0, 0);
    tick();
    tick();
    check_out("pc2", 2, 1, 0, 2);
    bus.Jump_en      = 1'b1;
    bus.Jump_address = 5'd7;
    bus.Branch_flag  = 1'b1;
    tick();
    clear_inputs();
    check("jump_taken", 32'(bus.PC), 32'd200);
    tick();
    check("after_jump", 32'(bus.PC), 32'd201);
    bus.Jump_en      = 1'b1;
    bus.Jump_address = 5'd7;
    bus.Branch_flag  = 1'b0;
    tick();
    clear_inputs();
    check("jump_not_taken", 32'(bus.PC), 32'd202);
    bus.Lut_we   = 1'b1;
    bus.Lut_addr = 5'd7;
    bus.Lut_data = 10'd55;
    tick();
    clear_inputs();
    check("lut_we_in_run", 32'(bus.PC), 32'd203);
    bus.Halt         = 1'b1;
    bus.Jump_en      = 1'b1;
    bus.Jump_address = 5'd7;
    bus.Branch_flag  = 1'b1;
    tick();
    clear_inputs();
    check_out("halt_over_jump", 203, 0, 1, 7);

    // Wrap at all-ones, then confirm the in-run write was dropped
    bus.Start_PC = 10'd1023;
    bus.Start    = 1'b1;
    tick();
    clear_inputs();
    check_out("start_1023", 1023, 1, 0, 0);
    tick();
    check("wrap", 32'(bus.PC), 32'd0);
    bus.Jump_en      = 1'b1;
    bus.Jump_address = 5'd7;
    bus.Branch_flag  = 1'b1;
    tick();
    clear_inputs();
    check("lut_kept", 32'(bus.PC), 32'd200);
    bus.Start    = 1'b1;
    bus.Start_PC = 10'd500;
    tick();
    clear_inputs();
    check_out("start_ignored", 201, 1, 0, 3);

    // Asynchronous reset between edges
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_out("async_rst", 0, 0, 0, 0);
    tick();
    rst = 1'b0;
    check_out("post_rst", 0, 0, 0, 0);

    // LUT must have been cleared by the reset
    bus.Start_PC = 10'd5;
    bus.Start    = 1'b1;
    tick();
    clear_inputs();
    check("start5", 32'(bus.PC), 32'd5);
    bus.Jump_en      = 1'b1;
    bus.Jump_address = 5'd7;
    bus.Branch_flag  = 1'b1;
    tick();
    clear_inputs();
    check("lut_cleared", 32'(bus.PC), 32'd0);
    bus.Halt = 1'b1;
    tick();
    clear_inputs();
    check_out("halt2", 0, 0, 1, 2);

    // Halt on the first instruction: exactly one RUN cycle
    bus.Start_PC = 10'd300;
    bus.Start    = 1'b1;
    tick();
    clear_inputs();
    check_out("start300", 300, 1, 0, 0);
    bus.Halt = 1'b1;
    tick();
    clear_inputs();
    check_out("halt_first", 300, 0, 1, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer and run controller for the single-cycle core. It owns the PC register and handles start/halt handshaking with the testbench or host. It resolves jumps through a 32-entry programmable target LUT indexed by the decoder's 5-bit jump address. It sits between the decoder outputs (Jump_en, Halt, Jump_address) and the instruction ROM address input, and also keeps a per-run cycle counter.

## Interface
- PC_W, 10, PC and LUT entry width in bits
- CNT_W, 16, cycle counter width
- CLK  input  1  system clock, rising edge
- Reset  input  1  asynchronous, active-high; one clock; reset is asynchronous and active-high
- Start  input  1  level/pulse; sampled in IDLE or HALTED to begin a run
- Start_PC  input  PC_W  PC loaded when a run begins
- Jump_en  input  1  decoder jump request for the current instruction
- Jump_address  input  5  decoder LUT index
- Branch_flag  input  1  ALU condition flag; the jump is taken only when it is 1
- Halt  input  1  decoder halt for the current instruction
- Lut_we  input  1  LUT write strobe
- Lut_addr  input  5  LUT write index
- Lut_data  input  PC_W  LUT write data
- PC  output  PC_W  instruction ROM address
- Run  output  1  high while an instruction is executing; gates Reg_writen/Mem_writen upstream
- Done  output  1  high from the cycle after halt until the next start
- Cycle_count  output  CNT_W  RUN cycles in the current/last run

## Operation
- States: IDLE (after reset), RUN, HALTED.
- Reset values: state=IDLE, PC=0, Run=0, Done=0, Cycle_count=0, all LUT entries=0.
- Transition IDLE→RUN: Start=1 at a clock edge. On that edge, PC←Start_PC and Cycle_count←0.
- RUN, at each edge, first match wins:
  - Halt=1 → HALTED. PC holds and Done←1.
  - Jump_en=1 and Branch_flag=1 → PC←LUT[Jump_address].
  - Otherwise PC←PC+1, modulo 2^PC_W: all-ones wraps to 0 with no error.
- Cycle_count in RUN: increments on every RUN edge, including the halting edge. It saturates at all-ones.
- Transition HALTED→RUN: Start=1 at an edge. This behaves identically to the IDLE→RUN transition, and Done←0 on the same edge.
- Start is ignored in RUN.
- Halt, Jump_en and Branch_flag are ignored outside RUN.
- Run is a combinational decode of state==RUN.
- Done is registered.
- LUT writes: accepted only when state≠RUN, and take effect at the edge. Writes while in RUN are dropped silently.
- LUT read is combinational, so a LUT entry written at edge n is visible from cycle n onward.
- Simultaneous Lut_we and Start in IDLE: both take effect. Jumps in the new run see the new entry.
- Reset asserted mid-run: immediately forces the reset values, including clearing the LUT.

## Timing
- Start→first fetch: one edge. PC=Start_PC and Run=1 in the cycle after the Start edge.
- Sequential and jump PC updates: zero extra latency. The next PC is visible the cycle after the instruction.
- Halt→Done: Done=1 and Run=0 in the cycle after the edge that sampled Halt.
- Halt at Start_PC: exactly one RUN cycle, giving Cycle_count=1.
- No combinational path from Start, Lut_* or Reset to PC. The only combinational output is Run (from state).

## Structure
- Shared package `seq_pkg` holds:
  - the state enum `seq_state_t` {IDLE, RUN, HALTED};
  - the LUT depth constant `JT_DEPTH=32`;
  - the default widths PC_W and CNT_W.
- One sub-module, `jump_lut`: 32×PC_W register file with one synchronous write port, one combinational read port and asynchronous reset. The top-level wires its write enable as Lut_we && state≠RUN.
- The top-level contains the FSM, the PC register/next-PC mux and the saturating counter.

## Test plan
- Reset then idle: Reset pulse with no Start for 5 cycles → PC=0, Run=0, Done=0, Cycle_count=0 throughout.
- Straight-line run: Start_PC=10, Start pulse, no jumps, Halt asserted in the 4th RUN cycle → PC sequence 10,11,12,13. Then Done=1, Run=0, PC held at 13, Cycle_count=4.
- Conditional jump:
  - LUT[7]=200 written in IDLE, run from 0. At PC=2 drive Jump_en=1, Jump_address=7, Branch_flag=1 → next PC=200.
  - Repeat with Branch_flag=0 → next PC=3.
- Priority and lockout:
  - Halt=1 with Jump_en=1, Branch_flag=1 → HALTED, and PC stays unchanged.
  - Lut_we to entry 7 during RUN → LUT[7] still reads 200 after the halt.
- Wrap, restart and async reset:
  - With PC_W=10, Start_PC=1023 → next PC=0.
  - Start while HALTED → Done falls, PC=Start_PC, Cycle_count restarts at 0.
  - Reset asserted mid-cycle during RUN → state IDLE, PC=0 and LUT cleared before the next edge.
